ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the data width of the RAM and of both requester ports.
REQ-002 Parameter ADDRESS_WIDTH, default 8, is the address width of the RAM and of both requester ports.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port a_req / b_req, input, 1 bit each: a request is pending.
REQ-007 Port a_we / b_we, input, 1 bit each: 1 selects write, 0 selects read.
REQ-008 Port a_addr / b_addr, input, ADDRESS_WIDTH bits each: the access address.
REQ-009 Port a_wdata / b_wdata, input, DATA_WIDTH bits each: the write data.
REQ-010 Port a_gnt / b_gnt, output, 1 bit each: one-cycle pulse meaning the request was accepted.
REQ-011 Port a_rvalid / b_rvalid, output, 1 bit each: one-cycle pulse meaning the read data is valid.
REQ-012 Port a_rdata / b_rdata, output, DATA_WIDTH bits each: the read data, held until that requester's next rvalid.
REQ-013 Port ram_cs, ram_we and ram_oe, output, 1 bit each: chip select, write enable and output enable to the single-port RAM.
REQ-014 Port ram_address, output, ADDRESS_WIDTH bits: the RAM address.
REQ-015 Port ram_din, output, DATA_WIDTH bits: the RAM write data.
REQ-016 Port ram_dout, input, DATA_WIDTH bits: the RAM read data, valid the cycle after the read strobe while ram_address is held.

Function
REQ-017 The FSM SHALL have states IDLE, ACCESS and CAPTURE, and SHALL enter IDLE on reset.
REQ-018 In IDLE with any request pending, the FSM SHALL pick a winner, latch its we, addr and wdata, go to ACCESS, and pulse that requester's gnt in the first ACCESS cycle.
REQ-019 Arbitration SHALL be round-robin: with both requests pending, the requester not served last wins; with one request pending, that requester wins.
REQ-020 The last-served pointer SHALL reset to B, so that A wins the first tie.
REQ-021 In ACCESS for a write, the outputs SHALL be ram_cs=1, ram_we=1, ram_oe=0, ram_din=latched wdata, and the FSM SHALL then return to IDLE.
REQ-022 In ACCESS for a read, the outputs SHALL be ram_cs=1, ram_we=0, ram_oe=1, and the FSM SHALL then go to CAPTURE.
REQ-023 In CAPTURE, ram_cs SHALL be 0 and ram_address SHALL stay at the latched address.
REQ-024 At the end of CAPTURE, ram_dout SHALL be registered into the winner's rdata, its rvalid SHALL pulse in the next cycle, and the FSM SHALL return to IDLE.
REQ-025 In IDLE and CAPTURE, ram_cs, ram_we and ram_oe SHALL be 0; ram_we and ram_oe SHALL never be 1 together.
REQ-026 Latency: gnt comes 1 cycle after req is sampled in IDLE; rvalid comes 3 cycles after gnt.
REQ-027 Throughput: one write per 2 cycles; one read per 3 cycles.
REQ-028 A requester SHALL hold req, we, addr and wdata stable until its gnt; a req still high after gnt is treated as a new request.
REQ-029 Requests arriving in ACCESS or CAPTURE SHALL wait; no request SHALL be dropped.
REQ-030 Back-to-back requests from a single requester, with the other idle, SHALL all be served.

Reset
REQ-031 Reset SHALL force: state=IDLE; all gnt, all rvalid, ram_cs, ram_we and ram_oe to 0; ram_address, ram_din and both rdata to 0; pointer=B.
REQ-032 A reset during ACCESS or CAPTURE SHALL abort the access in the next cycle, with no rvalid and no further RAM strobe.

Structure
REQ-033 A shared package SHALL hold the state encoding (IDLE=2'd0, ACCESS=2'd1, CAPTURE=2'd2) and the defaults for DATA_WIDTH and ADDRESS_WIDTH.
REQ-034 The block SHALL have one sub-module, rr_arbiter2: a two-requester round-robin pick with pointer update, instantiated once.

Verification
REQ-035 With the arbiter connected to the single-port RAM: A writes 0x5A to address 0x03, then A reads address 0x03 -> a_rvalid pulses 3 cycles after the read gnt with a_rdata=0x5A.
REQ-036 A and B request in the same cycle (A writes 0x11 to 0x01, B writes 0x22 to 0x02) -> a_gnt comes first and b_gnt 2 cycles later; reads then return 0x11 and 0x22.
REQ-037 A and B both hold req high continuously for 6 grants -> grants alternate A, B, A, B, A, B.
REQ-038 Only B issues 4 back-to-back reads of addresses 0x00 to 0x03 after those addresses were written with 0xA0 to 0xA3 -> 4 b_rvalid pulses 3 cycles apart with data 0xA0 to 0xA3 in order.
REQ-039 rst is asserted in the CAPTURE cycle of a read by A -> no a_rvalid, all outputs 0 in the next cycle, and a_gnt is the next grant after rst drops.
REQ-040 The bench SHALL assert in every cycle that ram_we and ram_oe are never both 1 and that ram_cs=0 outside ACCESS.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared state encoding and default widths for the two-port RAM arbiter.
package ram_arbiter_pkg;

  localparam int unsigned DATA_WIDTH_DEF    = 8;
  localparam int unsigned ADDRESS_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_e;

endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Two-requester round-robin pick; the pointer remembers who was served last.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_update,
  output logic o_any_c,
  output logic o_pick_b_c
);

  logic r_last_b;

  assign o_any_c    = i_req_a | i_req_b;
  // B wins when alone, or on a tie when A was served last.
  assign o_pick_b_c = i_req_b & (~i_req_a | ~r_last_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_b <= 1'b1;
    end else if (i_update && o_any_c) begin
      r_last_b <= o_pick_b_c;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one single-port RAM: writes take 2 cycles,
// reads 3 cycles, with the read data handed back one cycle after capture.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_req,
  input  logic                     a_we,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]    a_wdata,
  output logic                     a_gnt,
  output logic                     a_rvalid,
  output logic [DATA_WIDTH-1:0]    a_rdata,
  input  logic                     b_req,
  input  logic                     b_we,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]    b_wdata,
  output logic                     b_gnt,
  output logic                     b_rvalid,
  output logic [DATA_WIDTH-1:0]    b_rdata,
  output logic                     ram_cs,
  output logic                     ram_we,
  output logic                     ram_oe,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]    ram_din,
  input  logic [DATA_WIDTH-1:0]    ram_dout
);

  state_e                   r_state;
  logic                     r_sel_b;
  logic                     r_we;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic                     r_a_gnt;
  logic                     r_b_gnt;
  logic                     r_a_rvalid;
  logic                     r_b_rvalid;
  logic [DATA_WIDTH-1:0]    r_a_rdata;
  logic [DATA_WIDTH-1:0]    r_b_rdata;
  logic                     r_ram_cs;
  logic                     r_ram_we;
  logic                     r_ram_oe;
  logic [DATA_WIDTH-1:0]    r_cap_data;
  logic                     r_cap_vld;
  logic                     r_cap_b;

  logic                     w_any;
  logic                     w_pick_b;
  logic                     w_update;
  logic                     w_sel_we;
  logic [ADDRESS_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0]    w_sel_wdata;

  assign w_update    = (r_state == IDLE);
  assign w_sel_we    = w_pick_b ? b_we    : a_we;
  assign w_sel_addr  = w_pick_b ? b_addr  : a_addr;
  assign w_sel_wdata = w_pick_b ? b_wdata : a_wdata;

  rr_arbiter2 u_rr (
    .clk        (clk),
    .rst        (rst),
    .i_req_a    (a_req),
    .i_req_b    (b_req),
    .i_update   (w_update),
    .o_any_c    (w_any),
    .o_pick_b_c (w_pick_b)
  );

  // Control FSM; RAM strobes are registered so they line up with the ACCESS state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sel_b    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_a_gnt    <= 1'b0;
      r_b_gnt    <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
      r_ram_cs   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_oe   <= 1'b0;
      r_cap_data <= '0;
      r_cap_vld  <= 1'b0;
      r_cap_b    <= 1'b0;
    end else begin
      r_a_gnt    <= 1'b0;
      r_b_gnt    <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_ram_cs   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_oe   <= 1'b0;
      r_cap_vld  <= 1'b0;

      // Hand captured read data to its owner together with the rvalid pulse.
      if (r_cap_vld) begin
        if (r_cap_b) begin
          r_b_rdata  <= r_cap_data;
          r_b_rvalid <= 1'b1;
        end else begin
          r_a_rdata  <= r_cap_data;
          r_a_rvalid <= 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state  <= ACCESS;
            r_sel_b  <= w_pick_b;
            r_we     <= w_sel_we;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_a_gnt  <= ~w_pick_b;
            r_b_gnt  <= w_pick_b;
            r_ram_cs <= 1'b1;
            r_ram_we <= w_sel_we;
            r_ram_oe <= ~w_sel_we;
          end
        end
        ACCESS: begin
          r_state <= r_we ? IDLE : CAPTURE;
        end
        CAPTURE: begin
          r_cap_data <= ram_dout;
          r_cap_vld  <= 1'b1;
          r_cap_b    <= r_sel_b;
          r_state    <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign a_gnt       = r_a_gnt;
  assign b_gnt       = r_b_gnt;
  assign a_rvalid    = r_a_rvalid;
  assign b_rvalid    = r_b_rvalid;
  assign a_rdata     = r_a_rdata;
  assign b_rdata     = r_b_rdata;
  assign ram_cs      = r_ram_cs;
  assign ram_we      = r_ram_we;
  assign ram_oe      = r_ram_oe;
  assign ram_address = r_addr;
  assign ram_din     = r_wdata;

endmodule
